// File: rtl/gol_frame_scheduler.sv
// gol_frame_scheduler
//
// Paces generations of a Game-of-Life update engine against display frames.
// Decides when the update engine may start a generation (free-running timer
// measured in vsync frames, or a single step request), tracks the number of
// completed generations, and flags vsync arriving while a generation is still
// in flight. It also arbitrates the single-port cell RAM between display
// scan-out (always first) and the update engine.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   run, step, speed    generation pacing controls (speed: 1/2/4/8 frames)
//   vsync_start         one-cycle pulse at start of vertical blanking
//   disp_req/disp_addr  display read request
//   upd_req/upd_addr/upd_we/upd_wdata   update-engine memory request
//   upd_done            update engine finished the generation
//   upd_start           one-cycle pulse launching a generation
//   disp_gnt/upd_gnt    memory grants
//   mem_addr/mem_we/mem_wdata   cell RAM port
//   busy, gen_count, overrun    status
module gol_frame_scheduler #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [1:0]        speed,
    input  logic              vsync_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_we,
    input  logic              upd_wdata,
    input  logic              upd_done,
    output logic              upd_start,
    output logic              disp_gnt,
    output logic              upd_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    output logic              busy,
    output logic [7:0]        gen_count,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] frame_cnt, frame_cnt_nxt;
    logic       step_pending, step_pending_nxt;
    logic [7:0] gen_count_nxt;
    logic       overrun_nxt;

    logic [3:0] divisor;
    logic [3:0] frame_inc;
    logic       timer_expired;

    // Frames per generation is a power of two; ">=" also covers a speed
    // change that leaves the counter already past the new divisor.
    assign divisor       = 4'd1 << speed;
    assign frame_inc     = frame_cnt + 4'd1;
    assign timer_expired = run && (frame_inc >= divisor);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= 4'd0;
            step_pending <= 1'b0;
            gen_count    <= 8'd0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_cnt    <= frame_cnt_nxt;
            step_pending <= step_pending_nxt;
            gen_count    <= gen_count_nxt;
            overrun      <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        frame_cnt_nxt    = frame_cnt;
        step_pending_nxt = step_pending | step;
        gen_count_nxt    = gen_count;
        overrun_nxt      = overrun;

        case (state)
            IDLE: begin
                if (vsync_start) begin
                    // A step arriving on the same cycle is folded into this
                    // launch so clearing step_pending cannot lose it.
                    if (step_pending || step || timer_expired) begin
                        state_nxt        = START;
                        frame_cnt_nxt    = 4'd0;
                        step_pending_nxt = 1'b0;
                    end else if (run) begin
                        frame_cnt_nxt = frame_inc;
                    end
                end
            end
            START: begin
                state_nxt = UPDATE;
                if (vsync_start) overrun_nxt = 1'b1;
            end
            UPDATE: begin
                if (vsync_start) overrun_nxt = 1'b1;
                if (upd_done) begin
                    state_nxt     = IDLE;
                    gen_count_nxt = gen_count + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!run) frame_cnt_nxt = 4'd0;
    end

    // Status and grants are gated by reset so they are quiet for the whole
    // reset cycle, before the state register has actually returned to IDLE.
    assign upd_start = (state == START) && !reset;
    assign busy      = (state != IDLE) && !reset;
    assign disp_gnt  = disp_req;
    assign upd_gnt   = upd_req && !disp_req && (state == UPDATE) && !reset;

    always_comb begin
        mem_addr = '0;
        if (disp_gnt)     mem_addr = disp_addr;
        else if (upd_gnt) mem_addr = upd_addr;
    end

    assign mem_we    = upd_gnt & upd_we;
    assign mem_wdata = upd_wdata & upd_gnt;

endmodule

// File: doc/gol_frame_scheduler.md
GOL_FRAME_SCHEDULER -- requirements
Module: gol_frame_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, cell-memory address width (256 cells).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run  input  1  level: free-running generations enabled.
REQ-005 SHALL have port step  input  1  one-cycle pulse: request a single generation.
REQ-006 SHALL have port speed  input  2  frames per generation: 0->1, 1->2, 2->4, 3->8.
REQ-007 SHALL have port vsync_start  input  1  one-cycle pulse at the start of vertical blanking.
REQ-008 SHALL have port disp_req  input  1  display scan-out read request.
REQ-009 SHALL have port disp_addr  input  ADDR_W  display read address.
REQ-010 SHALL have ports upd_req (input, 1), upd_addr (input, ADDR_W), upd_we (input, 1) and upd_wdata (input, 1); these form the update-engine memory request.
REQ-011 SHALL have port upd_done  input  1  one-cycle pulse: the update engine finished the generation.
REQ-012 SHALL have port upd_start  output  1  one-cycle pulse: the update engine begins a generation.
REQ-013 SHALL have ports disp_gnt and upd_gnt  output  1 each  memory grants.
REQ-014 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1) and mem_wdata (output, 1); these drive the single-port cell RAM.
REQ-015 SHALL have ports busy (output, 1), gen_count (output, 8) and overrun (output, 1).

Function
REQ-016 SHALL implement FSM states IDLE, START, UPDATE.
REQ-017 SHALL, in IDLE on vsync_start, go to START when step_pending=1 or (run=1 and frame_cnt+1 == divisor(speed)); otherwise, if run=1, increment frame_cnt.
REQ-018 SHALL clear frame_cnt to 0 and step_pending to 0 on every IDLE->START transition; a simultaneous step and timer expiry launches exactly one generation.
REQ-019 SHALL hold frame_cnt at 0 while run=0.
REQ-020 SHALL set step_pending on any step pulse in any state; a step that arrives during START/UPDATE is serviced at the next eligible vsync_start.
REQ-021 SHALL, in START, assert upd_start for exactly that one cycle and go to UPDATE on the next edge.
REQ-022 SHALL, in UPDATE on upd_done, go to IDLE and increment gen_count modulo 256 (255->0).
REQ-023 SHALL ignore upd_done outside UPDATE.
REQ-024 SHALL drive busy=1 in START and UPDATE, and 0 in IDLE.
REQ-025 SHALL set overrun (sticky until reset) when vsync_start occurs in START or UPDATE; such a pulse SHALL NOT advance frame_cnt.
REQ-026 SHALL compute grants combinationally: disp_gnt=disp_req; upd_gnt=upd_req & ~disp_req & (state==UPDATE); the display always has priority.
REQ-027 SHALL drive mem_addr=disp_addr when disp_gnt, mem_addr=upd_addr when upd_gnt, and 0 otherwise.
REQ-028 SHALL drive mem_we=upd_gnt & upd_we and mem_wdata=upd_wdata & upd_gnt; mem_we SHALL never be 1 while disp_req=1.
REQ-029 SHALL NOT grant upd_req outside UPDATE, even when the memory is idle.
REQ-030 SHALL treat a speed change as taking effect at the next vsync_start comparison; if frame_cnt+1 > divisor, it SHALL treat this as expiry.

Reset
REQ-031 SHALL, when reset=1 at posedge, set: state=IDLE, frame_cnt=0, step_pending=0, gen_count=0, overrun=0.
REQ-032 SHALL, during reset, drive upd_start=0, busy=0, upd_gnt=0 and mem_we=0, while disp_gnt still follows disp_req.
REQ-033 SHALL, on reset asserted mid-UPDATE, abandon the generation; a later upd_done SHALL be ignored and gen_count SHALL stay 0.

Verification
REQ-034 SHALL verify: run=1, speed=2, five vsync_start pulses -> upd_start is seen exactly once, one cycle after the 4th pulse; upd_done -> gen_count=1.
REQ-035 SHALL verify: run=0, step pulse, then vsync_start -> one upd_start; a second vsync_start without step -> no upd_start.
REQ-036 SHALL verify: in UPDATE, with disp_req=1 and upd_req=1 (upd_we=1, addresses 0x12 and 0x34) -> disp_gnt=1, upd_gnt=0, mem_addr=0x12, mem_we=0; after disp_req drops -> mem_addr=0x34, mem_we=1.
REQ-037 SHALL verify: vsync_start during UPDATE -> overrun=1 and it stays 1 after upd_done; reset -> overrun=0.
REQ-038 SHALL verify: 256 completed generations -> gen_count wraps to 0.
REQ-039 SHALL verify: reset asserted in UPDATE, then upd_done -> state=IDLE, busy=0, gen_count=0.
